uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 16 +
 rtl/bit_synchronizer.sv | 30 +++
 rtl/uart_rx.sv | 167 ++++++++++++++++
 tb/tb_uart_rx.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: rx state encodings, data width and default bit timing.
// Also intended for the companion uart_tx.
package uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int CLKS_PER_BIT_DEFAULT = 1250;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_e;

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous bit.
// Flops load RESET_VAL while the synchronous active-low reset is held.
module bit_synchronizer #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 by default; define UART_RX_PARITY_EN for 8E1 with
// parity checking. Outputs are registered one-cycle strobes.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rcv_data,
    output logic                 rcv_ready,
    output logic                 frame_error,
    output logic                 parity_error
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(CLKS_PER_BIT - 1);

    logic rx_s;

    rx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2:0]           idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 prev_q, prev_d;
    logic                 ready_q, ready_d;
    logic                 ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad_q, par_bad_d;
    logic                 perr_q, perr_d;
`endif

    bit_synchronizer #(
        .STAGES    (2),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        prev_d  = rx_s;
        ready_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
        perr_d    = 1'b0;
`endif
        unique case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                // Only a falling edge starts a frame; a stuck-low line does not.
                if (prev_q && !rx_s) begin
                    state_d = RX_START;
                end
            end
            RX_START: begin
                if (cnt_q == HALF) begin
                    cnt_d   = '0;
                    state_d = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = RX_PARITY;
`else
                        state_d = RX_STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            RX_PARITY: begin
                if (cnt_q == FULL) begin
                    cnt_d     = '0;
                    par_bad_d = ^{shift_q, rx_s};
                    state_d   = RX_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            RX_STOP: begin
                if (cnt_q == FULL) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    if (!rx_s) begin
                        ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                    end else if (par_bad_q) begin
                        perr_d = 1'b1;
`endif
                    end else begin
                        data_d  = shift_q;
                        ready_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = RX_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            prev_q  <= 1'b1;
            ready_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            prev_q  <= prev_d;
            ready_q <= ready_d;
            ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= par_bad_d;
            perr_q    <= perr_d;
`endif
        end
    end

    assign rcv_data    = data_q;
    assign rcv_ready   = ready_q;
    assign frame_error = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign parity_error = perr_q;
`else
    assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clocks per bit: directed frames
// followed by random frames, gaps and glitches against a frame-level model.
module tb_uart_rx;

    localparam int C = 16;
`ifdef UART_RX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int LAT = 2 + C / 2 + (NB - 1) * C;

    localparam int K_READY = 0;
    localparam int K_FERR  = 1;
    localparam int K_PERR  = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rcv_data;
    logic       rcv_ready;
    logic       frame_error;
    logic       parity_error;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int fall_cyc = 0;
    int ready_cyc = 0;
    int n_ready = 0;
    int n_ferr = 0;
    int n_perr = 0;
    logic prev_any = 1'b0;
    logic [7:0] exp_data = 8'h00;
    logic [7:0] got_q[$];

    uart_rx #(.CLKS_PER_BIT(C)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx),
        .rcv_data     (rcv_data),
        .rcv_ready    (rcv_ready),
        .frame_error  (frame_error),
        .parity_error (parity_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rcv_ready || frame_error || parity_error) begin
            check("onehot", int'(rcv_ready) + int'(frame_error)
                  + int'(parity_error), 1);
            check("no_consec", {31'b0, prev_any}, 0);
        end
        prev_any = rcv_ready | frame_error | parity_error;
        if (rcv_ready) begin
            n_ready++;
            got_q.push_back(rcv_data);
            ready_cyc = cyc;
        end
        if (frame_error) n_ferr++;
        if (parity_error) n_perr++;
    end

    // Frame bits in line order, index 0 first: start, data LSB first, [parity], stop.
    function automatic logic [NB-1:0] mk_frame(input logic [7:0] b,
                                               input logic stop,
                                               input logic par);
`ifdef UART_RX_PARITY_EN
        return {stop, par, b, 1'b0};
`else
        return {stop, b, 1'b0} | NB'(par & 1'b0);
`endif
    endfunction

    function automatic int expect_kind(input logic [NB-1:0] f);
        if (!f[NB-1]) return K_FERR;
`ifdef UART_RX_PARITY_EN
        if (^f[NB-2:1]) return K_PERR;
`endif
        return K_READY;
    endfunction

    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_frame(input logic [NB-1:0] f, input string tag);
        int r0, fe0, pe0, k, lat;
        r0 = n_ready;
        fe0 = n_ferr;
        pe0 = n_perr;
        k = expect_kind(f);
        got_q.delete();
        fall_cyc = cyc;
        for (int i = 0; i < NB; i++) hold(f[i], C);
        check({tag, "/ready"}, n_ready - r0, (k == K_READY) ? 1 : 0);
        check({tag, "/ferr"}, n_ferr - fe0, (k == K_FERR) ? 1 : 0);
        check({tag, "/perr"}, n_perr - pe0, (k == K_PERR) ? 1 : 0);
        if (k == K_READY) begin
            exp_data = f[8:1];
            lat = ready_cyc - fall_cyc;
            check({tag, "/latency"}, {31'b0, (lat >= LAT - 1 && lat <= LAT + 1)}, 1);
            if (got_q.size() > 0) check({tag, "/strobe_data"}, got_q[0], exp_data);
        end
        check({tag, "/rcv_data"}, rcv_data, exp_data);
    endtask

    task automatic quiet(input string tag, input int r0, input int fe0,
                         input int pe0);
        check({tag, "/ready"}, n_ready - r0, 0);
        check({tag, "/ferr"}, n_ferr - fe0, 0);
        check({tag, "/perr"}, n_perr - pe0, 0);
    endtask

    initial begin
        int r0, fe0, pe0, gap;
        logic [7:0] b;
        logic stop, par;

        repeat (3) @(posedge clk);
        #1;
        check("rst/rcv_data", rcv_data, 8'h00);
        check("rst/rcv_ready", {31'b0, rcv_ready}, 0);
        check("rst/frame_error", {31'b0, frame_error}, 0);
        check("rst/parity_error", {31'b0, parity_error}, 0);
        reset = 1'b1;
        hold(1'b1, 2 * C);

        do_frame(mk_frame(8'h85, 1'b1, 1'b1), "f85");
        hold(1'b1, C);

        r0 = n_ready; fe0 = n_ferr; pe0 = n_perr;
        hold(1'b0, 4);
        hold(1'b1, 2 * C);
        quiet("glitch", r0, fe0, pe0);
        do_frame(mk_frame(8'h20, 1'b1, 1'b1), "f20");
        hold(1'b1, C);

        do_frame(mk_frame(8'h41, 1'b0, 1'b0), "f41_ferr");
        r0 = n_ready; fe0 = n_ferr; pe0 = n_perr;
        hold(1'b0, 3 * C);
        quiet("held_low", r0, fe0, pe0);
        hold(1'b1, 2 * C);

        do_frame(mk_frame(8'h20, 1'b1, 1'b1), "b2b_20");
        do_frame(mk_frame(8'h47, 1'b1, 1'b0), "b2b_47");
        hold(1'b1, C);

        r0 = n_ready; fe0 = n_ferr; pe0 = n_perr;
        hold(1'b0, C);
        hold(1'b1, 3 * C + C / 2);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_data = 8'h00;
        check("midrst/rcv_data", rcv_data, 8'h00);
        check("midrst/rcv_ready", {31'b0, rcv_ready}, 0);
        check("midrst/frame_error", {31'b0, frame_error}, 0);
        hold(1'b1, C / 2 + (NB - 5) * C);
        quiet("midrst", r0, fe0, pe0);
        check("midrst/hold", rcv_data, 8'h00);
        do_frame(mk_frame(8'h81, 1'b1, 1'b0), "f81");
        hold(1'b1, C);

`ifdef UART_RX_PARITY_EN
        do_frame(mk_frame(8'h03, 1'b1, 1'b1), "par_bad");
        hold(1'b1, C);
        do_frame(mk_frame(8'h03, 1'b1, 1'b0), "par_good");
        hold(1'b1, C);
`endif

        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                r0 = n_ready; fe0 = n_ferr; pe0 = n_perr;
                hold(1'b0, $urandom_range(1, 6));
                hold(1'b1, 2 * C);
                quiet("rnd_glitch", r0, fe0, pe0);
            end
            b = 8'($urandom);
            stop = ($urandom_range(0, 7) != 0);
            par = 1'($urandom_range(0, 1));
            gap = $urandom_range(0, 3);
            if (!stop && gap == 0) gap = 1;
            do_frame(mk_frame(b, stop, par), "rnd");
            hold(1'b1, gap * C);
        end

        hold(1'b1, 2 * C);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
